scan_reduce_wb: RTL and testbench

SCAN_REDUCE_WB -- requirements
Module: scan_reduce_wb

---
 rtl/scan_reduce_wb_if.sv | 30 +++
 rtl/scan_reduce_wb.sv | 118 +++++++++++
 tb/tb_scan_reduce_wb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/scan_reduce_wb_if.sv
// Host-side bundle of scan_reduce_wb: memory load port, scan start/mode, and scan results.
// The host drives go/mode/ld_*; the scanner drives status and results.
interface scan_reduce_wb_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             go;
  logic [1:0]       mode;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] max;
  logic [WIDTH+AW-1:0] sum;
  logic [AW:0]      over_cnt;

  modport master (
    output go, mode, ld_en, ld_addr, ld_data,
    input  busy, done, min, max, sum, over_cnt
  );

  modport slave (
    input  go, mode, ld_en, ld_addr, ld_data,
    output busy, done, min, max, sum, over_cnt
  );
endinterface

// File: rtl/scan_reduce_wb.sv
// Scans a DEPTH-word memory for min/max/sum/over-threshold count, optionally rewriting words >= THRESH.
// Latency go->done is 2*DEPTH + writebacks + 1; go and host loads are ignored while busy.
module scan_reduce_wb #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int THRESH = 128
) (
  input logic             Clk,
  input logic             Rst,
  scan_reduce_wb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH + AW;
  localparam logic [WIDTH-1:0] TH = WIDTH'(THRESH);

  typedef enum logic [2:0] {IDLE, RD, EV, WR, FIN} state_t;

  state_t           state;
  logic [AW-1:0]    index;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [SW-1:0]    sum_q;
  logic [AW:0]      over_q;

  logic             over_hit;
  logic             wb_take;
  logic             last;
  logic [WIDTH-1:0] wb_data;

  assign over_hit = (rd_data >= TH);
  assign wb_take  = over_hit && (mode_q == 2'b01 || mode_q == 2'b10);
  assign wb_data  = (mode_q == 2'b01) ? (rd_data - TH) : (TH - WIDTH'(1));
  assign last     = (index == AW'(DEPTH - 1));

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.min      = min_q;
  assign bus.max      = max_q;
  assign bus.sum      = sum_q;
  assign bus.over_cnt = over_q;

  // Memory has no reset so its contents survive Rst; a write-back is dropped in the reset cycle.
  always_ff @(posedge Clk) begin
    if (state == WR && !Rst) begin
      mem[index] <= wb_data;
    end else if (bus.ld_en && !busy_q) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
    if (state == RD) begin
      rd_data <= mem[index];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      index  <= '0;
      mode_q <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      over_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            index  <= '0;
            sum_q  <= '0;
            over_q <= '0;
            min_q  <= '1;
            max_q  <= '0;
            mode_q <= bus.mode;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= RD;
          end
        end
        RD: state <= EV;
        EV: begin
          if (rd_data < min_q) min_q <= rd_data;
          if (rd_data > max_q) max_q <= rd_data;
          sum_q <= sum_q + SW'(rd_data);
          if (over_hit) over_q <= over_q + (AW + 1)'(1);
          if (wb_take) begin
            state <= WR;
          end else if (last) begin
            state <= FIN;
          end else begin
            index <= index + AW'(1);
            state <= RD;
          end
        end
        WR: begin
          if (last) begin
            state <= FIN;
          end else begin
            index <= index + AW'(1);
            state <= RD;
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_reduce_wb.sv
// Directed bench for scan_reduce_wb: stimulus queues expected results, a done-edge monitor checks them.
module tb_scan_reduce_wb;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [11:0] sm;
    logic [4:0]  oc;
    int          lat;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   go_cyc = 0;
  logic done_prev = 1'b0;
  exp_t exp_q[$];

  scan_reduce_wb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

  scan_reduce_wb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THRESH(128)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every rising edge of done consumes one queued expectation.
  always @(negedge Clk) begin
    if (ifc.done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with no scan outstanding at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("min", ifc.min, e.mn);
        chk("max", ifc.max, e.mx);
        chk("sum", ifc.sum, e.sm);
        chk("over_cnt", ifc.over_cnt, e.oc);
        chk("latency", cyc - go_cyc, e.lat);
      end
    end
    done_prev <= ifc.done;
  end

  task automatic load_all(input int base, input int step);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge Clk);
      ifc.ld_en   = 1'b1;
      ifc.ld_addr = 4'(i);
      ifc.ld_data = 8'(base + step * i);
    end
    @(negedge Clk);
    ifc.ld_en = 1'b0;
  endtask

  task automatic start(input logic [1:0] m);
    @(negedge Clk);
    ifc.mode = m;
    ifc.go   = 1'b1;
    @(posedge Clk);
    #1;
    go_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge Clk);
  endtask

  task automatic run_scan(input logic [1:0] m, input exp_t e, input bit disturb);
    exp_q.push_back(e);
    start(m);
    ifc.go = 1'b0;
    if (disturb) begin
      repeat (4) @(negedge Clk);
      ifc.ld_en   = 1'b1;
      ifc.ld_addr = 4'd0;
      ifc.ld_data = 8'd99;
      ifc.go      = 1'b1;
      @(negedge Clk);
      ifc.ld_en = 1'b0;
      ifc.go    = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int k;
    ifc.go = 1'b0; ifc.mode = 2'b00; ifc.ld_en = 1'b0; ifc.ld_addr = '0; ifc.ld_data = '0;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_min", ifc.min, 255);
    chk("rst_max", ifc.max, 0);
    chk("rst_sum", ifc.sum, 0);
    chk("rst_over", ifc.over_cnt, 0);
    Rst = 1'b0;

    // mem[i] = 10*i, subtract mode rewrites 130,140,150
    load_all(0, 10);
    run_scan(2'b01, '{8'd0, 8'd150, 12'd1200, 5'd3, 36}, 1'b0);
    chk("mem13", dut.mem[13], 2);
    chk("mem14", dut.mem[14], 12);
    chk("mem15", dut.mem[15], 22);
    chk("mem12", dut.mem[12], 120);

    run_scan(2'b00, '{8'd0, 8'd120, 12'd816, 5'd0, 33}, 1'b0);
    chk("mem13_kept", dut.mem[13], 2);
    repeat (5) @(negedge Clk);
    chk("done_held", ifc.done, 1);
    chk("sum_held", ifc.sum, 816);

    run_scan(2'b11, '{8'd0, 8'd120, 12'd816, 5'd0, 33}, 1'b0);

    // go held high through FIN: second scan starts on the next IDLE cycle
    exp_q.push_back('{8'd0, 8'd120, 12'd816, 5'd0, 33});
    exp_q.push_back('{8'd0, 8'd120, 12'd816, 5'd0, 67});
    start(2'b00);
    while (cyc < go_cyc + 40) @(negedge Clk);
    ifc.go = 1'b0;
    wait_done();

    // host write and go during a scan are ignored
    run_scan(2'b00, '{8'd0, 8'd120, 12'd816, 5'd0, 33}, 1'b1);
    chk("mem0_ld_ignored", dut.mem[0], 0);

    // reset mid-scan
    start(2'b00);
    ifc.go = 1'b0;
    k = 0;
    while (dut.index != 4'd5 && k < 100) begin
      @(negedge Clk);
      k++;
    end
    chk("reach_index5", dut.index, 5);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_sum", ifc.sum, 0);
    repeat (80) @(negedge Clk);
    chk("abort_no_restart", ifc.busy, 0);
    run_scan(2'b00, '{8'd0, 8'd120, 12'd816, 5'd0, 33}, 1'b0);

    // all 255, clamp mode
    load_all(255, 0);
    run_scan(2'b10, '{8'd255, 8'd255, 12'd4080, 5'd16, 49}, 1'b0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("clamp_mem%0d", i), dut.mem[i], 127);
    run_scan(2'b00, '{8'd127, 8'd127, 12'd2032, 5'd0, 33}, 1'b0);

    // all zero, subtract mode: nothing written back
    load_all(0, 0);
    run_scan(2'b01, '{8'd0, 8'd0, 12'd0, 5'd0, 33}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
